// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is added DIGIT bits
//   per clock, least-significant digit first, under a start/busy/done
//   handshake. Sum, carry/borrow-out and signed overflow are registered and
//   held until the next completion.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   request, sampled while busy=0
//   sub      in   0: a+b+c_in, 1: a-b-c_in (c_in is borrow-in)
//   a, b     in   WIDTH-bit operands, sampled with start
//   c_in     in   carry-in / borrow-in, sampled with start
//   busy     out  operation in progress
//   done     out  one-cycle pulse when results update
//   sum      out  WIDTH-bit result
//   c_out    out  carry-out (add) / borrow-out (sub)
//   overflow out  two's-complement signed overflow
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_sub;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [DIGIT-1:0]   w_da;
  logic [DIGIT-1:0]   w_db;
  logic [DIGIT:0]     w_dsum;
  logic               w_c_msb;
  logic [WIDTH-1:0]   w_acc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(NDIG - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are shifted right each RUN cycle, so the active digit is always
  // the low slice.
  assign w_da   = r_a[DIGIT-1:0];
  assign w_db   = r_b[DIGIT-1:0];
  assign w_dsum = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};

  // Carry into the top bit of the digit: recover it from that bit's sum.
  // Only meaningful on the last digit, where it is the carry into the MSB.
  assign w_c_msb = w_dsum[DIGIT-1] ^ w_da[DIGIT-1] ^ w_db[DIGIT-1];

  // New digit enters at the top; after NDIG shifts the result is aligned.
  assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        // Subtraction is a + ~b + 1 - borrow_in, hence the inverted B and
        // the inverted carry-in.
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= c_in ^ sub;
        r_sub   <= sub;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_acc   <= w_acc_nxt;
        r_carry <= w_dsum[DIGIT];
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_sum  <= w_acc_nxt;
          r_cout <= w_dsum[DIGIT] ^ r_sub;
          r_ovf  <= w_c_msb ^ w_dsum[DIGIT];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign sum      = r_sum;
  assign c_out    = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder
//   Scoreboard bench for digit_serial_adder at WIDTH=16 with DIGIT=4, 1 and 16.
//   Expected results are queued when an operation is issued and compared when
//   the matching instance pulses done.
module tb_digit_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sub;
  logic [15:0] a, b;
  logic        c_in;
  logic        start4, start1, start16;

  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q16[$];

  logic pd4 = 1'b0, pd1 = 1'b0, pd16 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4),
    .overflow(ovf4));

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1),
    .overflow(ovf1));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16),
    .overflow(ovf16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [15:0] aa,
                                 input logic [15:0] bb, input logic ci);
    exp_t        e;
    logic [16:0] r;
    int          sr;
    if (!s) begin
      r  = {1'b0, aa} + {1'b0, bb} + 17'(ci);
      sr = int'($signed(aa)) + int'($signed(bb)) + int'(ci);
    end else begin
      r  = {1'b0, aa} - {1'b0, bb} - 17'(ci);
      sr = int'($signed(aa)) - int'($signed(bb)) - int'(ci);
    end
    e.s = r[15:0];
    e.c = r[16];
    e.o = (sr > 32767) || (sr < -32768);
    e.t = 0;
    return e;
  endfunction

  task automatic mon(input string tg, input exp_t e, input logic [15:0] s,
                     input logic c, input logic o, input int lat);
    chk({tg, "_sum"}, 32'(s), 32'(e.s));
    chk({tg, "_cout"}, 32'(c), 32'(e.c));
    chk({tg, "_ovf"}, 32'(o), 32'(e.o));
    chk({tg, "_latency"}, 32'(cyc - e.t), 32'(lat));
  endtask

  always @(negedge clk) begin
    if (done4) begin
      if (pd4) chk("d4_done_width", 32'(done4), 32'd0);
      if (q4.size() == 0) chk("d4_spurious_done", 32'd1, 32'd0);
      else mon("d4", q4.pop_front(), sum4, cout4, ovf4, 5);
    end
    pd4 = done4;
  end

  always @(negedge clk) begin
    if (done1) begin
      if (pd1) chk("d1_done_width", 32'(done1), 32'd0);
      if (q1.size() == 0) chk("d1_spurious_done", 32'd1, 32'd0);
      else mon("d1", q1.pop_front(), sum1, cout1, ovf1, 17);
    end
    pd1 = done1;
  end

  always @(negedge clk) begin
    if (done16) begin
      if (pd16) chk("d16_done_width", 32'(done16), 32'd0);
      if (q16.size() == 0) chk("d16_spurious_done", 32'd1, 32'd0);
      else mon("d16", q16.pop_front(), sum16, cout16, ovf16, 2);
    end
    pd16 = done16;
  end

  // Called at a negedge; start is sampled at the following posedge. Returns
  // at the negedge after that edge.
  task automatic issue(input bit en4, input bit en1, input bit en16, input logic s,
                       input logic [15:0] aa, input logic [15:0] bb, input logic ci);
    exp_t e;
    e   = model(s, aa, bb, ci);
    e.t = cyc;
    sub = s; a = aa; b = bb; c_in = ci;
    start4 = en4; start1 = en1; start16 = en16;
    if (en4)  q4.push_back(e);
    if (en1)  q1.push_back(e);
    if (en16) q16.push_back(e);
    @(negedge clk);
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!busy4 && !busy1 && !busy16 &&
          q4.size() == 0 && q1.size() == 0 && q16.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      q4.delete(); q1.delete(); q16.delete();
    end
  endtask

  initial begin
    int   n;
    bit   seen;
    logic s, ci;
    logic [15:0] ra, rb;

    reset = 1'b1; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_sum", 32'(sum4), 32'd0);
    chk("rst_cout", 32'(cout4), 32'd0);
    chk("rst_ovf", 32'(ovf4), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Plain add, with busy width measured on the DIGIT=4 instance
    issue(1, 1, 1, 1'b0, 16'h1234, 16'h0FCD, 1'b0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (done4) break;
      if (busy4) n++;
      @(negedge clk);
    end
    chk("add_busy_cycles", 32'(n), 32'd4);
    chk("add_sum_literal", 32'(sum4), 32'h2201);
    wait_idle("add");

    // Carry wrap and signed overflow corners
    issue(1, 1, 1, 1'b0, 16'hFFFF, 16'h0001, 1'b0); wait_idle("wrap");
    chk("wrap_cout_literal", 32'(cout4), 32'd1);
    issue(1, 1, 1, 1'b0, 16'h7FFF, 16'h0001, 1'b0); wait_idle("ovf_add");
    chk("ovf_add_literal", 32'(ovf4), 32'd1);
    issue(1, 1, 1, 1'b1, 16'h0005, 16'h0007, 1'b0); wait_idle("sub1");
    chk("sub1_sum_literal", 32'(sum4), 32'hFFFE);
    issue(1, 1, 1, 1'b1, 16'h8000, 16'h0001, 1'b0); wait_idle("sub2");
    chk("sub2_sum_literal", 32'(sum4), 32'h7FFF);
    issue(1, 1, 1, 1'b1, 16'h8000, 16'h0000, 1'b1); wait_idle("sub_bin");
    issue(1, 1, 1, 1'b0, 16'h7FFF, 16'h0000, 1'b1); wait_idle("add_cin");

    // Start while busy is ignored; start in the done cycle is accepted
    issue(1, 0, 0, 1'b0, 16'h1111, 16'h2222, 1'b0);
    start4 = 1'b1; sub = 1'b1; a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done4) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("hs_first_done_seen", 32'(seen), 32'd1);
    chk("hs_first_sum", 32'(sum4), 32'h3333);
    issue(1, 0, 0, 1'b0, 16'h0100, 16'h0020, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("hs_sum_held", 32'(sum4), 32'h3333);
      chk("hs_busy_b2b", 32'(busy4), 32'd1);
      if (i < 3) @(negedge clk);
    end
    wait_idle("hs");
    chk("hs_second_sum", 32'(sum4), 32'h0120);

    // Reset on the second RUN edge aborts the operation
    issue(1, 0, 0, 1'b0, 16'h1234, 16'h0001, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    q4.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_sum", 32'(sum4), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    issue(1, 0, 0, 1'b0, 16'h0003, 16'h0004, 1'b0); wait_idle("post_abort");
    chk("post_abort_sum", 32'(sum4), 32'h0007);

    // Random sweep on all three digit sizes
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      s  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      issue(1, 1, 1, s, ra, rb, ci);
      wait_idle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
